// File: rtl/fifth_pkg.sv
// Shared definitions for the fifth core stack unit: delta encoding and
// its sign extension.
package fifth_pkg;

  // 2-bit two's-complement pointer change applied by an op cycle.
  localparam logic [1:0] DELTA_PUSH = 2'b01;  // +1
  localparam logic [1:0] DELTA_NONE = 2'b00;  //  0
  localparam logic [1:0] DELTA_POP1 = 2'b11;  // -1
  localparam logic [1:0] DELTA_POP2 = 2'b10;  // -2

  // Sign-extend a delta code to a full integer; callers size-cast it to
  // the pointer or counter width they need.
  function automatic int sext_delta(input logic [1:0] code);
    case (code)
      DELTA_PUSH: return 1;
      DELTA_POP1: return -1;
      DELTA_POP2: return -2;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/fifth_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports
// for the top two entries, and one synchronous read port for the peek path.
module fifth_stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] top_addr,
  output logic [WIDTH-1:0] top_data,
  input  logic [PTR_W-1:0] second_addr,
  output logic [WIDTH-1:0] second_data,
  input  logic [PTR_W-1:0] peek_addr,
  output logic [WIDTH-1:0] peek_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus registered peek read; the peek sees the pre-write value.
  // NOTE: no reset on the array or its read register -- a reset here would
  // turn the RAM into flops; contents are don't-care until written.
  // NOTE: non-blocking assignments make the peek read the old contents when
  // the same slot is written on the same edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    peek_data <= mem[peek_addr];
  end

  // Combinational reads feeding the core's T/N registers.
  assign top_data    = mem[top_addr];
  assign second_data = mem[second_addr];

endmodule

// File: rtl/fifth_stack_ctl.sv
// Stack controller for the fifth core: stack pointer, occupancy counter,
// overflow/underflow detection with protect-or-wrap policy, top/second
// outputs and a registered debug peek port.
module fifth_stack_ctl
  import fifth_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter bit PROTECT = 1'b1,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       delta,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [PTR_W:0]   depth,
  output logic             full,
  output logic             empty,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             fault,
  input  logic [PTR_W-1:0] peek_index,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_hit
);

  // Signed width wide enough for depth in 0..DEPTH plus a -2..+1 change.
  localparam int DW = PTR_W + 2;
  localparam logic signed [DW-1:0] DEPTH_S   = DW'(DEPTH);
  localparam logic        [PTR_W:0] DEPTH_U  = (PTR_W + 1)'(DEPTH);
  localparam logic        [PTR_W-1:0] SP_RST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]     sp;
  logic [PTR_W-1:0]     sp_next;
  logic [PTR_W-1:0]     target_sp;
  logic [PTR_W:0]       depth_next;
  logic signed [DW-1:0] new_depth;
  logic                 ovf;
  logic                 unf;
  logic                 commit;
  logic                 ram_we;
  logic [WIDTH-1:0]     ram_top;
  logic [WIDTH-1:0]     ram_second;
  logic [WIDTH-1:0]     ram_peek;

  // Op evaluation: candidate depth, error detection, and whether the op lands.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    new_depth  = $signed({1'b0, depth}) + DW'(sext_delta(delta));
    target_sp  = sp + PTR_W'(sext_delta(delta));
    ovf        = 1'b0;
    unf        = 1'b0;
    commit     = 1'b0;
    sp_next    = sp;
    depth_next = depth;
    ram_we     = 1'b0;
    if (op_valid) begin
      ovf    = new_depth > DEPTH_S;
      unf    = new_depth[DW-1] || (write_en && new_depth == '0);
      // Protect mode drops an erroring op; wrap mode lets the pointer move.
      commit = !(ovf || unf) || !PROTECT;
    end
    if (commit) begin
      sp_next = target_sp;
      ram_we  = write_en;
      if (ovf)      depth_next = DEPTH_U;
      else if (unf) depth_next = '0;
      else          depth_next = new_depth[PTR_W:0];
    end
  end

  // Pointer, occupancy, sticky flags, fault pulse and peek hit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp            <= SP_RST;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      fault         <= 1'b0;
      peek_hit      <= 1'b0;
    end else begin
      sp            <= sp_next;
      depth         <= depth_next;
      // A new error outranks a simultaneous clear.
      err_overflow  <= ovf || (err_overflow && !clear_err);
      err_underflow <= unf || (err_underflow && !clear_err);
      fault         <= ovf || unf;
      peek_hit      <= {1'b0, peek_index} < depth;
    end
  end

  fifth_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk         (clk),
    .we          (ram_we),
    .waddr       (target_sp),
    .wdata       (write_data),
    .top_addr    (sp),
    .top_data    (ram_top),
    .second_addr (sp - PTR_W'(1)),
    .second_data (ram_second),
    .peek_addr   (sp - peek_index),
    .peek_data   (ram_peek)
  );

  // Occupancy-gated views of the storage.
  assign empty     = depth == '0;
  assign full      = depth == DEPTH_U;
  assign top       = empty ? '0 : ram_top;
  assign second    = (depth[PTR_W:1] == '0) ? '0 : ram_second;
  assign peek_data = peek_hit ? ram_peek : '0;

endmodule

// File: tb/tb_fifth_stack_ctl.sv
// Bench for fifth_stack_ctl: a protect-mode and a wrap-mode instance driven
// by shared directed stimulus, checked every cycle against an abstract stack
// model, plus literal expectations at key points.
module tb_fifth_stack_ctl;
  import fifth_pkg::*;

  localparam int W = 16;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    delta = 2'b00;
  logic          write_en = 1'b0;
  logic [W-1:0]  write_data = '0;
  logic          clear_err = 1'b0;
  logic [3:0]    peek_index = '0;

  logic [W-1:0]  p_top, p_second, p_pd, w_top, w_second, w_pd;
  logic [4:0]    p_depth, w_depth;
  logic          p_full, p_empty, p_eo, p_eu, p_fault, p_ph;
  logic          w_full, w_empty, w_eo, w_eu, w_fault, w_ph;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifth_stack_ctl #(.WIDTH(W), .DEPTH(D), .PROTECT(1'b1)) dut_p (
    .clk(clk), .reset(reset), .op_valid(op_valid), .delta(delta),
    .write_en(write_en), .write_data(write_data), .clear_err(clear_err),
    .top(p_top), .second(p_second), .depth(p_depth), .full(p_full),
    .empty(p_empty), .err_overflow(p_eo), .err_underflow(p_eu),
    .fault(p_fault), .peek_index(peek_index), .peek_data(p_pd),
    .peek_hit(p_ph)
  );

  fifth_stack_ctl #(.WIDTH(W), .DEPTH(D), .PROTECT(1'b0)) dut_w (
    .clk(clk), .reset(reset), .op_valid(op_valid), .delta(delta),
    .write_en(write_en), .write_data(write_data), .clear_err(clear_err),
    .top(w_top), .second(w_second), .depth(w_depth), .full(w_full),
    .empty(w_empty), .err_overflow(w_eo), .err_underflow(w_eu),
    .fault(w_fault), .peek_index(peek_index), .peek_data(w_pd),
    .peek_hit(w_ph)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- abstract model: index 0 = protect, 1 = wrap ----------
  int          m_sp [2];
  int          m_cnt[2];
  logic [15:0] m_mem[2][16];
  bit          m_eo[2], m_eu[2], m_fault[2], m_ph[2];
  logic [15:0] m_pd[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sp[k] = D - 1; m_cnt[k] = 0;
      m_eo[k] = 0; m_eu[k] = 0; m_fault[k] = 0; m_ph[k] = 0; m_pd[k] = '0;
    end
  endtask

  task automatic model_step();
    int d, nd;
    bit ovf, unf;
    for (int k = 0; k < 2; k++) begin
      if (int'(peek_index) < m_cnt[k]) begin
        m_pd[k] = m_mem[k][(m_sp[k] - int'(peek_index) + D) % D];
        m_ph[k] = 1;
      end else begin
        m_pd[k] = '0;
        m_ph[k] = 0;
      end
      case (delta)
        2'b01:   d = 1;
        2'b11:   d = -1;
        2'b10:   d = -2;
        default: d = 0;
      endcase
      ovf = 0; unf = 0;
      if (op_valid) begin
        nd  = m_cnt[k] + d;
        ovf = nd > D;
        unf = (nd < 0) || (write_en && nd == 0);
        if (!(ovf || unf) || k == 1) begin
          m_sp[k] = (m_sp[k] + d + D) % D;
          if (write_en) m_mem[k][m_sp[k]] = write_data;
          m_cnt[k] = ovf ? D : (unf ? 0 : nd);
        end
      end
      m_fault[k] = ovf || unf;
      m_eo[k] = ovf || (m_eo[k] && !clear_err);
      m_eu[k] = unf || (m_eu[k] && !clear_err);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic cmp(input int k, input logic [15:0] top_v, second_v,
                     input logic [4:0] depth_v,
                     input logic full_v, empty_v, eo_v, eu_v, fault_v,
                     input logic [15:0] pd_v, input logic ph_v);
    string tag;
    logic [15:0] e_top, e_sec;
    tag   = (k == 0) ? "prot" : "wrap";
    e_top = (m_cnt[k] == 0) ? 16'h0 : m_mem[k][m_sp[k]];
    e_sec = (m_cnt[k] < 2)  ? 16'h0 : m_mem[k][(m_sp[k] + D - 1) % D];
    check({tag, ".top"},    top_v,    e_top);
    check({tag, ".second"}, second_v, e_sec);
    check({tag, ".depth"},  depth_v,  m_cnt[k]);
    check({tag, ".full"},   full_v,   m_cnt[k] == D);
    check({tag, ".empty"},  empty_v,  m_cnt[k] == 0);
    check({tag, ".err_ov"}, eo_v,     m_eo[k]);
    check({tag, ".err_un"}, eu_v,     m_eu[k]);
    check({tag, ".fault"},  fault_v,  m_fault[k]);
    check({tag, ".peek_d"}, pd_v,     m_pd[k]);
    check({tag, ".peek_h"}, ph_v,     m_ph[k]);
  endtask

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, p_top, p_second, p_depth, p_full, p_empty, p_eo, p_eu, p_fault, p_pd, p_ph);
      cmp(1, w_top, w_second, w_depth, w_full, w_empty, w_eo, w_eu, w_fault, w_pd, w_ph);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input logic [1:0] d, input logic we,
                       input logic [15:0] data, input logic clr);
    op_valid = 1'b1; delta = d; write_en = we; write_data = data; clear_err = clr;
    @(posedge clk); #1;
    op_valid = 1'b0; delta = DELTA_NONE; write_en = 1'b0; write_data = '0;
    clear_err = 1'b0;
  endtask

  task automatic clear_flags();
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < D; i++) m_mem[k][i] = '0;
    model_reset();
    idle(3);
    chk_en = 1'b1;
    check("rst.depth", p_depth, 0);
    check("rst.empty", p_empty, 1);
    check("rst.top",   p_top,   0);
    check("rst.flags", {p_eo, p_eu, p_fault, p_ph}, 0);
    reset = 1'b1;
    idle(1);

    // Three pushes.
    do_op(DELTA_PUSH, 1'b1, 16'h1111, 1'b0);
    do_op(DELTA_PUSH, 1'b1, 16'h2222, 1'b0);
    do_op(DELTA_PUSH, 1'b1, 16'h3333, 1'b0);
    check("push3.top",    p_top,    16'h3333);
    check("push3.second", p_second, 16'h2222);
    check("push3.depth",  p_depth,  3);
    check("push3.empty",  p_empty,  0);
    check("push3.err",    {p_eo, p_eu}, 0);
    check("push3.wtop",   w_top,    16'h3333);

    // Peek: bottom entry, out-of-range index, same-cycle write.
    peek_index = 4'd2; idle(1);
    check("peek2.data", p_pd, 16'h1111);
    check("peek2.hit",  p_ph, 1);
    peek_index = 4'd3; idle(1);
    check("peek3.data", p_pd, 16'h0);
    check("peek3.hit",  p_ph, 0);
    peek_index = 4'd0;
    do_op(DELTA_NONE, 1'b1, 16'h4444, 1'b0);
    check("peek_rbw.old", p_pd,  16'h3333);
    check("peek_rbw.top", p_top, 16'h4444);
    idle(1);
    check("peek_rbw.new", p_pd,  16'h4444);

    // op_valid low ignores delta and write_en.
    delta = DELTA_PUSH; write_en = 1'b1; write_data = 16'hFFFF;
    idle(1);
    delta = DELTA_NONE; write_en = 1'b0; write_data = '0;
    check("idle.depth", p_depth, 3);
    check("idle.top",   p_top,   16'h4444);

    // Pop two, then replace top.
    do_op(DELTA_POP2, 1'b0, 16'h0, 1'b0);
    check("pop2.top",    p_top,    16'h1111);
    check("pop2.second", p_second, 16'h0);
    check("pop2.depth",  p_depth,  1);
    do_op(DELTA_NONE, 1'b1, 16'hBEEF, 1'b0);
    check("repl.top",   p_top,   16'hBEEF);
    check("repl.depth", p_depth, 1);

    // Pop-with-write to depth 0 is an underflow.
    do_op(DELTA_POP1, 1'b1, 16'h5555, 1'b0);
    check("popw.pdepth", p_depth, 1);
    check("popw.ptop",   p_top,   16'hBEEF);
    check("popw.perr",   p_eu,    1);
    check("popw.pfault", p_fault, 1);
    check("popw.wdepth", w_depth, 0);
    check("popw.werr",   w_eu,    1);
    idle(1);
    check("popw.fault1", p_fault, 0);
    clear_flags();
    check("clr.flags", {p_eu, w_eu}, 0);

    // Fresh start for the fill test.
    reset = 1'b0; idle(2); reset = 1'b1; idle(1);
    for (int i = 0; i < D; i++) do_op(DELTA_PUSH, 1'b1, 16'(i), 1'b0);
    check("fill.depth",  p_depth,  16);
    check("fill.full",   p_full,   1);
    check("fill.top",    p_top,    16'h000F);
    check("fill.second", p_second, 16'h000E);
    do_op(DELTA_PUSH, 1'b1, 16'hAAAA, 1'b0);
    check("ovf.pdepth",  p_depth,  16);
    check("ovf.ptop",    p_top,    16'h000F);
    check("ovf.perr",    p_eo,     1);
    check("ovf.pfault",  p_fault,  1);
    check("ovf.wtop",    w_top,    16'hAAAA);
    check("ovf.wsecond", w_second, 16'h000F);
    check("ovf.wdepth",  w_depth,  16);
    check("ovf.werr",    w_eo,     1);
    idle(1);
    check("ovf.fault1", {p_fault, w_fault}, 0);
    clear_flags();
    check("ovf.clr", {p_eo, w_eo}, 0);
    do_op(DELTA_PUSH, 1'b1, 16'hBBBB, 1'b1);
    check("setwins.p",  p_eo,     1);
    check("setwins.w",  w_eo,     1);
    check("setwins.wt", w_top,    16'hBBBB);
    clear_flags();

    // Drain and underflow.
    repeat (D) do_op(DELTA_POP1, 1'b0, 16'h0, 1'b0);
    check("drain.depth", p_depth, 0);
    check("drain.empty", p_empty, 1);
    check("drain.top",   p_top,   0);
    do_op(DELTA_POP1, 1'b0, 16'h0, 1'b0);
    check("unf.depth", p_depth, 0);
    check("unf.err",   p_eu,    1);
    check("unf.fault", p_fault, 1);
    check("unf.werr",  w_eu,    1);
    do_op(DELTA_NONE, 1'b1, 16'h7777, 1'b0);
    check("unf0w.fault", p_fault, 1);
    clear_flags();
    do_op(DELTA_PUSH, 1'b1, 16'h1234, 1'b0);
    do_op(DELTA_POP2, 1'b0, 16'h0, 1'b0);
    check("pop2unf.depth", p_depth, 1);
    check("pop2unf.err",   p_eu,    1);
    check("pop2unf.wdep",  w_depth, 0);

    // Asynchronous reset in the middle of a push burst.
    do_op(DELTA_PUSH, 1'b1, 16'h0A0A, 1'b0);
    do_op(DELTA_PUSH, 1'b1, 16'h0B0B, 1'b0);
    op_valid = 1'b1; delta = DELTA_PUSH; write_en = 1'b1; write_data = 16'h0C0C;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("arst.depth", p_depth, 0);
    check("arst.top",   p_top,   0);
    check("arst.flags", {p_eo, p_eu, p_fault}, 0);
    check("arst.wdep",  w_depth, 0);
    op_valid = 1'b0; delta = DELTA_NONE; write_en = 1'b0; write_data = '0;
    idle(1);
    reset = 1'b1;
    idle(2);
    check("arst.peek", p_ph, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifth_stack_ctl.md
Name: fifth_stack_ctl

Overview:
- Parametrised stack unit for the next-generation fifth core; one instance serves as the data stack and one as the return stack.
- Contains the stack pointer, an occupancy counter, and overflow/underflow detection with a selectable protect-or-wrap policy.
- Exposes the top two entries combinationally for the core's T/N/R datapath, plus a registered debug peek port.

Parameters:
- WIDTH, 16: entry width in bits.
- DEPTH, 16: number of entries; must be a power of two and ≥4. Local PTR_W = $clog2(DEPTH).
- PROTECT, 1: 1 = an op that would overflow or underflow is suppressed; 0 = pointer wraps modulo DEPTH (legacy behaviour).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  apply delta/write this cycle.
- delta  in  2  signed pointer change: 01 = +1, 00 = 0, 11 = -1, 10 = -2.
- write_en  in  1  write write_data at the post-delta pointer.
- write_data  in  WIDTH  data written.
- clear_err  in  1  clears the sticky error flags.
- top  out  WIDTH  entry at sp; 0 when depth = 0.
- second  out  WIDTH  entry at sp-1; 0 when depth < 2.
- depth  out  PTR_W+1  occupancy, 0..DEPTH.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- err_overflow  out  1  sticky overflow flag.
- err_underflow  out  1  sticky underflow flag.
- fault  out  1  one-cycle pulse, registered, on any op that raised an error.
- peek_index  in  PTR_W  offset from top (0 = top).
- peek_data  out  WIDTH  registered entry at sp - peek_index; 1-cycle latency.
- peek_hit  out  1  registered; peek_index < depth at the sample edge.

Behaviour:
- Reset: async on reset low. sp = DEPTH-1 so the first push lands at 0. depth = 0. err_* = 0, fault = 0, peek_data = 0, peek_hit = 0. Storage contents are not cleared.
- Op cycle (op_valid = 1): new_depth = depth + sext(delta), computed in PTR_W+2 signed bits.
  - Overflow: new_depth > DEPTH.
  - Underflow: new_depth < 0, or write_en = 1 with new_depth == 0.
  - Legal op: sp <= sp + sext(delta) mod DEPTH; depth <= new_depth; if write_en, store[sp + sext(delta)] <= write_data.
  - delta 0 with write_en replaces top. delta -1 with write_en overwrites the new top.
  - Error with PROTECT = 1: sp, depth and storage are unchanged; the matching err_* is set; fault pulses the next cycle.
  - Error with PROTECT = 0: sp moves and the write occurs (wrapping); depth saturates to DEPTH or 0; err_* is set; fault pulses.
- op_valid = 0: no state change; delta and write_en are ignored.
- Error flags: sticky until clear_err. If a set and clear_err occur in the same cycle, the set wins.
- top and second are combinational from current sp and depth. A write becomes visible after the clock edge; there is no forwarding.
- Peek: sampled every cycle. The registered read is read-before-write, so a same-cycle write to the peeked slot returns the old value. When peek_index ≥ depth, peek_data = 0 and peek_hit = 0.
- Only pointer and counter arithmetic are modulo DEPTH; depth itself never wraps.

Decomposition:
- Package fifth_pkg holds:
  - delta encoding constants: DELTA_PUSH, DELTA_NONE, DELTA_POP1, DELTA_POP2;
  - a sign-extension function for delta.
- Sub-module fifth_stack_ram: DEPTH × WIDTH storage with one synchronous write port, two asynchronous read ports (top, second) and one synchronous read port (peek).
- fifth_stack_ctl holds sp, depth, the error logic and the peek registers.

Test Plan:
- Reset low, then release; push 0x1111, 0x2222, 0x3333 -> top = 0x3333, second = 0x2222, depth = 3, empty = 0, no errors.
- From depth 3, delta -2 with no write -> top = 0x1111, second = 0, depth = 1; then delta 0 with write 0xBEEF -> top = 0xBEEF, depth = 1.
- PROTECT = 1, fill 16 entries, then push 0xDEAD -> depth stays 16, top unchanged, err_overflow = 1, fault high for exactly one cycle; then pop to empty and pop again -> depth = 0, err_underflow = 1.
- PROTECT = 0, 16 pushes of i, then push 0xAAAA -> slot 0 overwritten, top = 0xAAAA, depth = 16, err_overflow = 1.
- Depth 3, peek_index = 2 -> next cycle peek_data = bottom value, peek_hit = 1. peek_index = 3 -> peek_data = 0, peek_hit = 0. Same-cycle write to the peeked slot -> old value returned.
- clear_err asserted in the same cycle as an overflowing push -> err_overflow remains 1. Asserting reset low mid-burst -> depth = 0, flags = 0, top = 0 immediately, without waiting for a clock edge.
